// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared definitions for the pipeline hazard and forwarding controller:
// default register width, forwarding select codes and FSM state encoding.
package hazard_ctrl_unit_pkg;

  localparam int unsigned REG_AW_DEF = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef enum logic {
    StRun   = 1'b0,
    StStall = 1'b1
  } state_e;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Bundle of pipeline-register fields consumed by the hazard controller and the
// stall/flush/forwarding controls it returns to the pipeline.
interface hazard_ctrl_unit_if #(
  parameter int unsigned REG_AW = hazard_ctrl_unit_pkg::REG_AW_DEF,
  parameter int unsigned CNT_W  = 32
) ();

  logic [REG_AW-1:0] rs_ID;
  logic [REG_AW-1:0] rt_ID;
  logic              uses_rs_ID;
  logic              uses_rt_ID;
  logic              Branch_ID;
  logic              RegWrite_IDEX;
  logic              MemRead_IDEX;
  logic [REG_AW-1:0] dest_IDEX;
  logic [REG_AW-1:0] rs_IDEX;
  logic [REG_AW-1:0] rt_IDEX;
  logic              RegWrite_EXMEM;
  logic              MemRead_EXMEM;
  logic [REG_AW-1:0] dest_EXMEM;
  logic              RegWrite_MEMWB;
  logic [REG_AW-1:0] dest_MEMWB;
  logic              redirect;

  logic              PCWrite;
  logic              IFIDWrite;
  logic              IDEX_Bubble;
  logic              IFID_Flush;
  logic              IDEX_Flush;
  logic [1:0]        FwdA;
  logic [1:0]        FwdB;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output rs_ID, rt_ID, uses_rs_ID, uses_rt_ID, Branch_ID,
    output RegWrite_IDEX, MemRead_IDEX, dest_IDEX, rs_IDEX, rt_IDEX,
    output RegWrite_EXMEM, MemRead_EXMEM, dest_EXMEM,
    output RegWrite_MEMWB, dest_MEMWB, redirect,
    input  PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, IDEX_Flush,
    input  FwdA, FwdB, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs_ID, rt_ID, uses_rs_ID, uses_rt_ID, Branch_ID,
    input  RegWrite_IDEX, MemRead_IDEX, dest_IDEX, rs_IDEX, rt_IDEX,
    input  RegWrite_EXMEM, MemRead_EXMEM, dest_EXMEM,
    input  RegWrite_MEMWB, dest_MEMWB, redirect,
    output PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, IDEX_Flush,
    output FwdA, FwdB, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_ctrl_unit_fwd_select.sv
// EX-operand forwarding select for one source register; the younger EX/MEM
// result wins over MEM/WB when both stages write the same register.
module hazard_ctrl_unit_fwd_select
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic [REG_AW-1:0] i_dest_exmem,
  input  logic              i_we_exmem,
  input  logic [REG_AW-1:0] i_dest_memwb,
  input  logic              i_we_memwb,
  output logic [1:0]        o_sel
);

  logic w_hit_exmem;
  logic w_hit_memwb;

  assign w_hit_exmem = i_we_exmem && (i_dest_exmem == i_src) && (i_dest_exmem != '0);
  assign w_hit_memwb = i_we_memwb && (i_dest_memwb == i_src) && (i_dest_memwb != '0);

  always_comb begin
    o_sel = FWD_RF;
    if (w_hit_exmem) begin
      o_sel = FWD_EXMEM;
    end else if (w_hit_memwb) begin
      o_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard and forwarding controller: multi-cycle load-use stall, branch-operand
// stall, redirect flushes, EX forwarding selects and saturating event counters.
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int unsigned REG_AW     = REG_AW_DEF,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned RESOLVE_EX = 0,
  parameter int unsigned CNT_W      = 32
) (
  input logic               Clk_in,
  input logic               Rst,
  hazard_ctrl_unit_if.slave bus
);

  localparam logic [3:0]       REM_INIT = 4'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           r_state;
  logic [3:0]       r_rem;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_lu;
  logic w_bh;
  logic w_stall;
  logic w_ifid_flush;

  function automatic logic f_match(logic [REG_AW-1:0] x, logic [REG_AW-1:0] d, logic we);
    return we && (d == x) && (d != '0);
  endfunction

  assign w_lu = bus.MemRead_IDEX &&
                ((bus.uses_rs_ID && f_match(bus.rs_ID, bus.dest_IDEX, 1'b1)) ||
                 (bus.uses_rt_ID && f_match(bus.rt_ID, bus.dest_IDEX, 1'b1)));

  // A branch compares in ID, so it waits on an ALU result still in EX or a load in MEM.
  assign w_bh = bus.Branch_ID &&
                ((bus.uses_rs_ID &&
                  (f_match(bus.rs_ID, bus.dest_IDEX, bus.RegWrite_IDEX) ||
                   f_match(bus.rs_ID, bus.dest_EXMEM, bus.MemRead_EXMEM))) ||
                 (bus.uses_rt_ID &&
                  (f_match(bus.rt_ID, bus.dest_IDEX, bus.RegWrite_IDEX) ||
                   f_match(bus.rt_ID, bus.dest_EXMEM, bus.MemRead_EXMEM))));

  assign w_stall      = w_lu || w_bh || (r_state == StStall);
  assign w_ifid_flush = bus.redirect && !w_stall;

  assign bus.PCWrite     = !w_stall;
  assign bus.IFIDWrite   = !w_stall;
  assign bus.IDEX_Bubble = w_stall;
  assign bus.IFID_Flush  = w_ifid_flush;
  assign bus.IDEX_Flush  = w_ifid_flush && (RESOLVE_EX != 0);
  assign bus.stall_cnt   = r_stall_cnt;
  assign bus.flush_cnt   = r_flush_cnt;

  always_ff @(posedge Clk_in) begin
    if (Rst) begin
      r_state     <= StRun;
      r_rem       <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      unique case (r_state)
        StRun: begin
          if (w_lu && (LOAD_LAT > 1)) begin
            r_state <= StStall;
            r_rem   <= REM_INIT;
          end
        end
        StStall: begin
          // New hazards seen here are already covered by the ongoing stall.
          if (r_rem == 4'd1) begin
            r_state <= StRun;
            r_rem   <= '0;
          end else begin
            r_rem <= r_rem - 4'd1;
          end
        end
      endcase
      if (w_stall && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_ifid_flush && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  hazard_ctrl_unit_fwd_select #(
    .REG_AW (REG_AW)
  ) u_fwd_a (
    .i_src        (bus.rs_IDEX),
    .i_dest_exmem (bus.dest_EXMEM),
    .i_we_exmem   (bus.RegWrite_EXMEM),
    .i_dest_memwb (bus.dest_MEMWB),
    .i_we_memwb   (bus.RegWrite_MEMWB),
    .o_sel        (bus.FwdA)
  );

  hazard_ctrl_unit_fwd_select #(
    .REG_AW (REG_AW)
  ) u_fwd_b (
    .i_src        (bus.rt_IDEX),
    .i_dest_exmem (bus.dest_EXMEM),
    .i_we_exmem   (bus.RegWrite_EXMEM),
    .i_dest_memwb (bus.dest_MEMWB),
    .i_we_memwb   (bus.RegWrite_MEMWB),
    .o_sel        (bus.FwdB)
  );

endmodule
